// File: rtl/sm_register_rv_if.sv
// Valid/ready bundle for the two-entry skid register: producer side, consumer side,
// flush and occupancy. The bench drives through master; the register uses slave.
interface sm_register_rv_if #(
    parameter int WIDTH = 1
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/sm_register_rv.sv
// Two-entry valid/ready pipeline register (skid buffer). Every output comes straight
// from flops, so no combinational path runs from in_valid/out_ready/flush to any output.
module sm_register_rv #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sm_register_rv_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    // Binary encoding doubles as the occupancy count.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign bus.count     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            // Flush wins over both handshakes; any fire this cycle is discarded.
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_BUSY;
                        main_d  = bus.in_data;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = bus.in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_register_rv.sv
// Self-checking bench for sm_register_rv: directed scenarios plus random traffic,
// checked by a queue-based reference model in a separate monitor process.
module tb_sm_register_rv;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;

    sm_register_rv_if #(.WIDTH(WIDTH)) bus ();

    sm_register_rv #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the words accepted but not yet delivered, in order.
    logic [WIDTH-1:0] model_q[$];
    bit               zero_exp;
    bit               hold_valid;
    logic [WIDTH-1:0] hold_data;
    bit               flush_seen_output;

    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            zero_exp   = 1'b1;
            hold_valid = 1'b0;
        end else begin
            check("count", 32'(bus.count), 32'(model_q.size()));
            check("in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
            check("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
            if (zero_exp && model_q.size() == 0)
                check("cleared_data", 32'(bus.out_data), 32'd0);
            if (hold_valid)
                check("stable_data", 32'(bus.out_data), 32'(hold_data));
            hold_valid = bus.out_valid & ~bus.out_ready & ~bus.flush;
            hold_data  = bus.out_data;

            if (bus.flush) begin
                model_q.delete();
                zero_exp = 1'b1;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (model_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL deliver: got 0x%0h, expected no word at %0t", bus.out_data, $time);
                    end else begin
                        check("deliver", 32'(bus.out_data), 32'(model_q.pop_front()));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    model_q.push_back(bus.in_data);
                    zero_exp = 1'b0;
                end
            end
        end
    end

    // Advance past the next rising edge; new inputs are then applied here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        check("reset_count", 32'(bus.count), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);

        // Pass-through with consumer always ready.
        drive(1'b1, 8'h01, 1'b1, 1'b0); step();
        check("pt_data1", 32'(bus.out_data), 32'h01);
        check("pt_count1", 32'(bus.count), 32'd1);
        drive(1'b1, 8'h02, 1'b1, 1'b0); step();
        check("pt_data2", 32'(bus.out_data), 32'h02);
        check("pt_ready2", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 8'h03, 1'b1, 1'b0); step();
        check("pt_data3", 32'(bus.out_data), 32'h03);
        check("pt_count3", 32'(bus.count), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0); step();
        check("pt_drain", 32'(bus.count), 32'd0);

        // Stall and skid.
        drive(1'b1, 8'hA5, 1'b0, 1'b0); step();
        drive(1'b1, 8'h5A, 1'b0, 1'b0); step();
        check("skid_count", 32'(bus.count), 32'd2);
        check("skid_in_ready", 32'(bus.in_ready), 32'd0);
        check("skid_head", 32'(bus.out_data), 32'hA5);
        drive(1'b0, 8'h00, 1'b1, 1'b0); step();
        check("skid_next", 32'(bus.out_data), 32'h5A);
        check("skid_count1", 32'(bus.count), 32'd1);
        check("skid_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        check("skid_empty", 32'(bus.count), 32'd0);

        // Simultaneous fire in BUSY.
        drive(1'b1, 8'h11, 1'b0, 1'b0); step();
        drive(1'b1, 8'h22, 1'b1, 1'b0); step();
        check("simul_data", 32'(bus.out_data), 32'h22);
        check("simul_count", 32'(bus.count), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0); step();

        // Flush while FULL, with both handshakes active.
        drive(1'b1, 8'h33, 1'b0, 1'b0); step();
        drive(1'b1, 8'h44, 1'b0, 1'b0); step();
        check("flush_pre", 32'(bus.count), 32'd2);
        drive(1'b1, 8'h55, 1'b1, 1'b1); step();
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_data", 32'(bus.out_data), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0); step();

        // Asynchronous reset mid-cycle with the buffer FULL.
        drive(1'b1, 8'h66, 1'b0, 1'b0); step();
        drive(1'b1, 8'h77, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("areset_out_valid", 32'(bus.out_valid), 32'd0);
        check("areset_in_ready", 32'(bus.in_ready), 32'd1);
        check("areset_count", 32'(bus.count), 32'd0);
        check("areset_data", 32'(bus.out_data), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0));
            step();
        end

        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) step();
        check("final_empty", 32'(bus.count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
